regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 32: register data width in bits.
REQ-002 SHALL have parameter AW, default 5: register address width; NREG = 2**AW registers.
REQ-003 SHALL have parameter NRP, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have parameters GP_INIT (default 32'h0000_1800) and SP_INIT (default 32'h0000_2ffc): reset values of registers 28 and 29.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port wr_en, input, 2: per-write-port enable, bit k for port k.
REQ-009 SHALL have ports wr_addr0/wr_addr1, input, AW each: write addresses.
REQ-010 SHALL have ports wr_data0/wr_data1, input, DW each: write data.
REQ-011 SHALL have port iss_en, input, 1: mark register iss_addr pending (instruction issued).
REQ-012 SHALL have port iss_addr, input, AW: destination register being issued.
REQ-013 SHALL have port rd_addr, input, NRP*AW: packed read addresses, port i at bits [i*AW +: AW].
REQ-014 SHALL have port rd_data, output, NRP*DW: packed read data, port i at [i*DW +: DW].
REQ-015 SHALL have port rd_busy, output, NRP: per-read-port pending flag.
REQ-016 SHALL have port busy_vec, output, NREG: registered pending bit per register.

Function
REQ-017 SHALL write wr_dataK into register wr_addrK at clock edge when wr_en[K]=1 and wr_addrK != 0.
REQ-018 SHALL, when both ports write the same nonzero address in one cycle, store wr_data1 (port 1 wins).
REQ-019 SHALL hold register 0 at zero: writes ignored, reads return 0, never pending, rd_busy=0.
REQ-020 SHALL read combinationally: rd_data port i = register[rd_addr_i], zero-latency.
REQ-021 SHALL, with BYPASS=1, return wr_data of a same-cycle enabled write to nonzero rd_addr_i (port 1 over port 0); with BYPASS=0 return the stored value (new value visible next cycle).
REQ-022 SHALL set busy_vec[iss_addr] at clock edge when iss_en=1 and iss_addr != 0.
REQ-023 SHALL clear busy_vec[a] at clock edge when any enabled write targets a.
REQ-024 SHALL, on simultaneous issue and write to the same address, leave the bit set (issue wins: newer producer).
REQ-025 SHALL drive rd_busy[i] = busy_vec[rd_addr_i], masked to 0 when BYPASS=1 and a same-cycle write to that address is forwarded.
REQ-026 SHALL treat issue to an already-pending register as no change (bit stays 1); write to non-pending register clears nothing extra and updates data normally.

Reset
REQ-027 SHALL, while rst=1, asynchronously force all registers to 0 except reg 28 = GP_INIT and reg 29 = SP_INIT (when NREG > 29).
REQ-028 SHALL, while rst=1, force busy_vec to all zero; writes and issues during reset are ignored.
REQ-029 SHALL resume normal writes/issues at the first rising clk edge after rst deasserts.
REQ-030 SHALL produce rd_data/rd_busy from reset contents during reset (e.g. read 29 -> 32'h0000_2ffc, busy 0).

Structure
REQ-031 SHALL take REG_ZERO=0, REG_GP=28, REG_SP=29 and default GP/SP init constants from shared package regfile_pkg.
REQ-032 SHALL instantiate one sub-module regfile_rdport per read port (address decode, bypass mux, busy mask).
REQ-033 SHALL keep storage and busy_vec in the top module; only flip-flop state is storage and busy_vec.

Verification
REQ-034 SHALL cover: reset then read 0/28/29/5 -> 0, 32'h1800, 32'h2ffc, 0; busy_vec all 0.
REQ-035 SHALL cover: wr_en=2'b11, both addr 7, data0=32'hAAAA_AAAA, data1=32'h5555_5555 -> reg 7 = 32'h5555_5555 next cycle; BYPASS=1 read 7 same cycle = 32'h5555_5555.
REQ-036 SHALL cover: write reg 0 with 32'hDEAD_BEEF, issue to 0 -> read 0 = 0, busy_vec[0]=0.
REQ-037 SHALL cover: issue 9 at cycle n -> busy_vec[9]=1 from n+1; write 9 with 32'h1234 at n+3 -> rd_busy 0 and data 32'h1234 same cycle (BYPASS=1), busy_vec[9]=0 at n+4.
REQ-038 SHALL cover: issue 12 and write 12 same cycle -> busy_vec[12]=1 after edge, data updated.
REQ-039 SHALL cover: rst asserted mid-operation with regs 3/9 written and 9 pending -> immediate return to reset values, busy_vec=0, without waiting for clk.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants: architectural register indices and the
// default reset values of the global and stack pointers.
package regfile_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_GP   = 28;
  localparam int unsigned REG_SP   = 29;

  localparam logic [31:0] GP_INIT_DEFAULT = 32'h0000_1800;
  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_2ffc;

  function automatic logic [31:0] reset_value(input int unsigned idx,
                                              input logic [31:0] gp,
                                              input logic [31:0] sp);
    if (idx == REG_GP) return gp;
    if (idx == REG_SP) return sp;
    return '0;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: register select, write-to-read forwarding
// and the pending-flag mask that goes with a forwarded value.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]      rd_addr,
  input  logic [DW-1:0]      reg_q [2**AW],
  input  logic [2**AW-1:0]   busy_vec,
  input  logic [1:0]         wr_en,
  input  logic [AW-1:0]      wr_addr0,
  input  logic [AW-1:0]      wr_addr1,
  input  logic [DW-1:0]      wr_data0,
  input  logic [DW-1:0]      wr_data1,
  output logic [DW-1:0]      rd_data,
  output logic               rd_busy
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic is_zero;
  logic hit0;
  logic hit1;

  always_comb begin
    is_zero = (rd_addr == ZERO_A);
    hit0    = (BYPASS != 0) && wr_en[0] && (wr_addr0 == rd_addr) && !is_zero;
    hit1    = (BYPASS != 0) && wr_en[1] && (wr_addr1 == rd_addr) && !is_zero;

    rd_data = '0;
    rd_busy = 1'b0;
    if (!is_zero) begin
      // port 1 is checked first so it wins, matching the storage priority
      if (hit1)      rd_data = wr_data1;
      else if (hit0) rd_data = wr_data0;
      else           rd_data = reg_q[rd_addr];
      rd_busy = busy_vec[rd_addr] && !(hit0 || hit1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRP-read register file with a per-register scoreboard of
// pending writes; register 0 is hard-wired to zero and never pending.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRP     = 2,
  parameter int unsigned BYPASS  = 1,
  parameter logic [31:0] GP_INIT = GP_INIT_DEFAULT,
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          wr_en,
  input  logic [AW-1:0]       wr_addr0,
  input  logic [AW-1:0]       wr_addr1,
  input  logic [DW-1:0]       wr_data0,
  input  logic [DW-1:0]       wr_data1,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*DW-1:0]   rd_data,
  output logic [NRP-1:0]      rd_busy,
  output logic [2**AW-1:0]    busy_vec
);

  localparam int unsigned   NREG   = 2**AW;
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [DW-1:0]   reg_q [NREG];
  logic [NREG-1:0] busy_nxt;
  logic [1:0]      wr_en_act;

  // Writes are ignored during reset, so they must not forward either;
  // otherwise a read during reset would not show reset contents.
  assign wr_en_act = rst ? 2'b00 : wr_en;

  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en_act[0]) busy_nxt[wr_addr0] = 1'b0;
    if (wr_en_act[1]) busy_nxt[wr_addr1] = 1'b0;
    // issue applied last: a newer producer outranks a completing write
    if (iss_en && (iss_addr != ZERO_A)) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        reg_q[i] <= DW'(reset_value(i, GP_INIT, SP_INIT));
      end
      busy_vec <= '0;
    end else begin
      if (wr_en[0] && (wr_addr0 != ZERO_A)) reg_q[wr_addr0] <= wr_data0;
      if (wr_en[1] && (wr_addr1 != ZERO_A)) reg_q[wr_addr1] <= wr_data1;
      busy_vec <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rdport
    regfile_rdport #(
      .DW     (DW),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rdport (
      .rd_addr  (rd_addr[i*AW +: AW]),
      .reg_q    (reg_q),
      .busy_vec (busy_vec),
      .wr_en    (wr_en_act),
      .wr_addr0 (wr_addr0),
      .wr_addr1 (wr_addr1),
      .wr_data0 (wr_data0),
      .wr_data1 (wr_data1),
      .rd_data  (rd_data[i*DW +: DW]),
      .rd_busy  (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default parameters): an architectural
// model checked every cycle, plus hand-computed literal expectations.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [4:0]  wr_addr0, wr_addr1, iss_addr, ra0, ra1;
  logic [31:0] wr_data0, wr_data1;
  logic        iss_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [31:0] busy_vec;

  assign rd_addr = {ra1, ra0};

  regfile_sb #(.DW(32), .AW(5), .NRP(2), .BYPASS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: register contents and pending set.
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_regs[28] = 32'h0000_1800;
      m_regs[29] = 32'h0000_2ffc;
      m_busy = 32'h0;
    end else begin
      if (wr_en[0] && wr_addr0 != 0) m_regs[wr_addr0] = wr_data0;
      if (wr_en[1] && wr_addr1 != 0) m_regs[wr_addr1] = wr_data1;
      if (wr_en[0]) m_busy[wr_addr0] = 1'b0;
      if (wr_en[1]) m_busy[wr_addr1] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (!rst && wr_en[1] && wr_addr1 == a) return wr_data1;
    if (!rst && wr_en[0] && wr_addr0 == a) return wr_data0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic fwd;
    fwd = !rst && ((wr_en[0] && wr_addr0 == a) || (wr_en[1] && wr_addr1 == a));
    return (a != 0) && m_busy[a] && !fwd;
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_rd_data0", rd_data[31:0],  exp_data(ra0));
      check("cmp_rd_data1", rd_data[63:32], exp_data(ra1));
      check("cmp_rd_busy0", {31'b0, rd_busy[0]}, {31'b0, exp_busy(ra0)});
      check("cmp_rd_busy1", {31'b0, rd_busy[1]}, {31'b0, exp_busy(ra1)});
      check("cmp_busy_vec", busy_vec, m_busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00; iss_en = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  r0;
    logic [4:0]  r1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'b01, 5'd1,  32'h0000_0011, 5'd0,  32'h0,         1'b0, 5'd0,  5'd1,  5'd31};
    vecs[1] = '{2'b10, 5'd0,  32'h0,         5'd31, 32'hFFFF_FFFF, 1'b1, 5'd1,  5'd31, 5'd1};
    vecs[2] = '{2'b11, 5'd2,  32'h0000_0222, 5'd4,  32'h0000_0444, 1'b1, 5'd4,  5'd2,  5'd4};
    vecs[3] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b1, 5'd4,  5'd4,  5'd1};
    vecs[4] = '{2'b01, 5'd1,  32'hCAFE_0001, 5'd0,  32'h0,         1'b0, 5'd0,  5'd1,  5'd4};
    vecs[5] = '{2'b10, 5'd0,  32'h0,         5'd4,  32'h0000_0555, 1'b0, 5'd0,  5'd4,  5'd28};
    vecs[6] = '{2'b11, 5'd28, 32'h1111_0000, 5'd29, 32'h2222_0000, 1'b1, 5'd29, 5'd28, 5'd29};
    vecs[7] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  5'd29, 5'd2};
  end

  initial begin
    rst = 1'b1; idle();
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0; iss_addr = '0;
    ra0 = 5'd29; ra1 = 5'd28;
    run_cmp = 1'b1;
    #12;
    check("rst_read29", rd_data[31:0],  32'h0000_2ffc);
    check("rst_read28", rd_data[63:32], 32'h0000_1800);
    check("rst_busy_vec", busy_vec, 32'h0);
    wr_en = 2'b11; wr_addr0 = 5'd29; wr_addr1 = 5'd28;
    wr_data0 = 32'h9999_9999; wr_data1 = 32'h8888_8888;
    iss_en = 1'b1; iss_addr = 5'd29;
    #1;
    check("rst_no_bypass", rd_data[31:0], 32'h0000_2ffc);
    step();
    check("rst_write_ignored", rd_data[31:0], 32'h0000_2ffc);
    check("rst_issue_ignored", busy_vec, 32'h0);
    idle();
    #1 rst = 1'b0;
    ra0 = 5'd0; ra1 = 5'd5;
    #1;
    check("read0_after_rst", rd_data[31:0],  32'h0);
    check("read5_after_rst", rd_data[63:32], 32'h0);

    // Dual write to the same register: port 1 wins, also when forwarded.
    step();
    wr_en = 2'b11; wr_addr0 = 5'd7; wr_addr1 = 5'd7;
    wr_data0 = 32'hAAAA_AAAA; wr_data1 = 32'h5555_5555;
    ra0 = 5'd7; ra1 = 5'd7;
    #1 check("bypass_dual_7", rd_data[31:0], 32'h5555_5555);
    step(); idle();
    #1 check("stored_dual_7", rd_data[63:32], 32'h5555_5555);

    // Register 0 ignores writes and issues.
    step();
    wr_en = 2'b01; wr_addr0 = 5'd0; wr_data0 = 32'hDEAD_BEEF;
    iss_en = 1'b1; iss_addr = 5'd0; ra0 = 5'd0;
    #1 check("zero_no_bypass", rd_data[31:0], 32'h0);
    step(); idle();
    #1;
    check("zero_read", rd_data[31:0], 32'h0);
    check("zero_not_busy", {31'b0, busy_vec[0]}, 32'h0);

    // Issue 9, re-issue while pending, complete three cycles later.
    iss_en = 1'b1; iss_addr = 5'd9; ra0 = 5'd9; ra1 = 5'd9;
    #1 check("busy9_before_edge", {31'b0, rd_busy[0]}, 32'h0);
    step();
    check("busy9_set", {31'b0, busy_vec[9]}, 32'h1);
    check("rd_busy9_set", {31'b0, rd_busy[0]}, 32'h1);
    step(); idle();
    check("busy9_reissue", {31'b0, busy_vec[9]}, 32'h1);
    step();
    wr_en = 2'b01; wr_addr0 = 5'd9; wr_data0 = 32'h0000_1234;
    #1;
    check("rd_busy9_fwd_mask", {31'b0, rd_busy[0]}, 32'h0);
    check("rd_data9_fwd", rd_data[31:0], 32'h0000_1234);
    check("busy9_still_set", {31'b0, busy_vec[9]}, 32'h1);
    step(); idle();
    check("busy9_cleared", {31'b0, busy_vec[9]}, 32'h0);

    // Issue and write to 12 together: pending bit stays, data updates.
    wr_en = 2'b10; wr_addr1 = 5'd12; wr_data1 = 32'h0000_7777;
    iss_en = 1'b1; iss_addr = 5'd12;
    step(); idle(); ra0 = 5'd12;
    #1;
    check("busy12_issue_wins", {31'b0, busy_vec[12]}, 32'h1);
    check("data12_updated", rd_data[31:0], 32'h0000_7777);
    check("rd_busy12", {31'b0, rd_busy[0]}, 32'h1);

    for (int k = 0; k < 8; k++) begin
      step();
      wr_en = vecs[k].we; wr_addr0 = vecs[k].a0; wr_data0 = vecs[k].d0;
      wr_addr1 = vecs[k].a1; wr_data1 = vecs[k].d1;
      iss_en = vecs[k].ie; iss_addr = vecs[k].ia;
      ra0 = vecs[k].r0; ra1 = vecs[k].r1;
    end
    step(); idle();
    ra0 = 5'd31; ra1 = 5'd29;
    #1;
    check("table_reg31", rd_data[31:0],  32'hFFFF_FFFF);
    check("table_reg29_busy", {31'b0, rd_busy[1]}, 32'h1);

    // Asynchronous reset mid-cycle with live state.
    step();
    wr_en = 2'b01; wr_addr0 = 5'd3; wr_data0 = 32'h0000_0033;
    iss_en = 1'b1; iss_addr = 5'd9;
    step(); idle();
    ra0 = 5'd3; ra1 = 5'd9;
    #1;
    check("pre_rst_reg3", rd_data[31:0], 32'h0000_0033);
    check("pre_rst_busy9", {31'b0, busy_vec[9]}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_reg3", rd_data[31:0], 32'h0);
    check("async_rst_reg9", rd_data[63:32], 32'h0);
    check("async_rst_busy", busy_vec, 32'h0);
    ra0 = 5'd28; ra1 = 5'd29;
    #1;
    check("async_rst_gp", rd_data[31:0],  32'h0000_1800);
    check("async_rst_sp", rd_data[63:32], 32'h0000_2ffc);
    step(); step();
    rst = 1'b0;
    step();
    wr_en = 2'b01; wr_addr0 = 5'd3; wr_data0 = 32'h0000_00A5;
    step(); idle(); ra0 = 5'd3;
    #1 check("post_rst_write", rd_data[31:0], 32'h0000_00A5);
    step(); step();
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
